// File: rtl/decoder_scan_n.sv
// ---------------------------------------------------------------------------
// decoder_scan_n
// Registered N-to-2**N one-hot decoder with a scan mode. In scan mode an
// internal index walks the one-hot output up or down, stepping once every
// DIV enabled cycles, with a load path and a one-cycle wrap pulse.
//
// Parameters
//   N          select width, output width is 2**N
//   DIV        scan prescaler, index steps every DIV enabled cycles (1..65535)
//   ACTIVE_LOW 1 = selected line driven 0, others 1
//
// Ports
//   i_clk    rising-edge clock
//   i_rst    synchronous reset, active-high
//   i_ena    enable; 0 = outputs inactive, counters frozen
//   i_mode   0 = decode i_n, 1 = scan
//   i_dir    scan direction; 0 = up, 1 = down
//   i_load   scan mode only: load i_n into the index
//   i_n      select value
//   o_d      registered one-hot output
//   o_idx    registered current index
//   o_valid  1 when o_d carries a selected line
//   o_wrap   one-cycle pulse coincident with a wrapped index on o_d
// ---------------------------------------------------------------------------
module decoder_scan_n #(
  parameter int N          = 3,
  parameter int DIV        = 1,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_ena,
  input  logic            i_mode,
  input  logic            i_dir,
  input  logic            i_load,
  input  logic [N-1:0]    i_n,
  output logic [2**N-1:0] o_d,
  output logic [N-1:0]    o_idx,
  output logic            o_valid,
  output logic            o_wrap
);

  localparam int W  = 2**N;
  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [W-1:0]  D_IDLE   = ACTIVE_LOW ? {W{1'b1}} : {W{1'b0}};
  localparam logic [N-1:0]  IDX_MAX  = {N{1'b1}};
  localparam logic [N-1:0]  IDX_ZERO = {N{1'b0}};
  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);
  localparam logic [W-1:0]  ONE      = {{(W-1){1'b0}}, 1'b1};

  logic [N-1:0]  r_idx;
  logic [PW-1:0] r_pre;
  logic [W-1:0]  r_d;
  logic          r_valid;
  logic          r_wrap;
  logic          r_mode_q;

  logic [N-1:0]  w_idx_nxt;
  logic [PW-1:0] w_pre_nxt;
  logic [W-1:0]  w_onehot;
  logic [W-1:0]  w_d_nxt;
  logic          w_valid_nxt;
  logic          w_wrap_nxt;

  always_comb begin
    w_idx_nxt   = r_idx;
    w_pre_nxt   = r_pre;
    w_valid_nxt = 1'b0;
    w_wrap_nxt  = 1'b0;
    if (!i_ena) begin
      // frozen: index and prescaler hold, output goes inactive
      w_valid_nxt = 1'b0;
    end else if (!i_mode) begin
      w_idx_nxt   = i_n;
      w_pre_nxt   = '0;
      w_valid_nxt = 1'b1;
    end else begin
      w_valid_nxt = 1'b1;
      if (i_load) begin
        w_idx_nxt = i_n;
        w_pre_nxt = '0;
      end else if (i_mode != r_mode_q) begin
        // first scan cycle after a mode change: restart the dwell, no step
        w_pre_nxt = '0;
      end else if (r_pre == PRE_LAST) begin
        w_pre_nxt = '0;
        if (!i_dir) begin
          w_idx_nxt  = r_idx + 1'b1;
          w_wrap_nxt = (r_idx == IDX_MAX);
        end else begin
          w_idx_nxt  = r_idx - 1'b1;
          w_wrap_nxt = (r_idx == IDX_ZERO);
        end
      end else begin
        w_pre_nxt = r_pre + 1'b1;
      end
    end
  end

  always_comb begin
    w_onehot = ONE << w_idx_nxt;
    if (!w_valid_nxt) begin
      w_d_nxt = D_IDLE;
    end else if (ACTIVE_LOW) begin
      w_d_nxt = ~w_onehot;
    end else begin
      w_d_nxt = w_onehot;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_idx    <= '0;
      r_pre    <= '0;
      r_d      <= D_IDLE;
      r_valid  <= 1'b0;
      r_wrap   <= 1'b0;
      r_mode_q <= 1'b0;
    end else begin
      r_idx    <= w_idx_nxt;
      r_pre    <= w_pre_nxt;
      r_d      <= w_d_nxt;
      r_valid  <= w_valid_nxt;
      r_wrap   <= w_wrap_nxt;
      r_mode_q <= i_mode;
    end
  end

  assign o_d     = r_d;
  assign o_idx   = r_idx;
  assign o_valid = r_valid;
  assign o_wrap  = r_wrap;

endmodule

// File: tb/tb_decoder_scan_n.sv
// ---------------------------------------------------------------------------
// tb_decoder_scan_n
// Directed bench for decoder_scan_n. Three instances share the control
// inputs: u0 (N=3, DIV=1), u3 (N=3, DIV=3) and u4 (N=4, DIV=1, ACTIVE_LOW=1).
// Inputs change 1 ns after a rising edge; outputs are sampled at that point.
// ---------------------------------------------------------------------------
module tb_decoder_scan_n;

  logic       clk = 1'b0;
  logic       rst, ena, mode, dir, load;
  logic [2:0] n3;
  logic [3:0] n4;

  logic [7:0]  d0, d3;
  logic [15:0] d4;
  logic [2:0]  idx0, idx3;
  logic [3:0]  idx4;
  logic        v0, v3, v4, w0, w3, w4;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  decoder_scan_n #(.N(3), .DIV(1), .ACTIVE_LOW(1'b0)) u0 (
    .i_clk(clk), .i_rst(rst), .i_ena(ena), .i_mode(mode), .i_dir(dir),
    .i_load(load), .i_n(n3), .o_d(d0), .o_idx(idx0), .o_valid(v0), .o_wrap(w0));

  decoder_scan_n #(.N(3), .DIV(3), .ACTIVE_LOW(1'b0)) u3 (
    .i_clk(clk), .i_rst(rst), .i_ena(ena), .i_mode(mode), .i_dir(dir),
    .i_load(load), .i_n(n3), .o_d(d3), .o_idx(idx3), .o_valid(v3), .o_wrap(w3));

  decoder_scan_n #(.N(4), .DIV(1), .ACTIVE_LOW(1'b1)) u4 (
    .i_clk(clk), .i_rst(rst), .i_ena(ena), .i_mode(mode), .i_dir(dir),
    .i_load(load), .i_n(n4), .o_d(d4), .o_idx(idx4), .o_valid(v4), .o_wrap(w4));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; ena = 1'b0; mode = 1'b0; dir = 1'b0; load = 1'b0;
    n3 = 3'd0; n4 = 4'd0;
    step();
    step();
    rst = 1'b0;
    step();
    n_cmp++;
    if (d0 !== 8'h00) begin n_bad++; $display("FAIL reset_d got %h want 00", d0); end
    n_cmp++;
    if (idx0 !== 3'd0) begin n_bad++; $display("FAIL reset_idx got %0d want 0", idx0); end
    n_cmp++;
    if (v0 !== 1'b0 || w0 !== 1'b0) begin
      n_bad++; $display("FAIL reset_valid_wrap got %b%b want 00", v0, w0);
    end
    n_cmp++;
    if (d4 !== 16'hFFFF) begin n_bad++; $display("FAIL reset_d_al got %h want FFFF", d4); end
  endtask

  task automatic test_decode();
    logic [7:0] exp_d;
    ena = 1'b1; mode = 1'b0;
    for (int i = 0; i < 8; i++) begin
      n3 = 3'(i);
      step();
      exp_d = 8'h01 << i;
      n_cmp++;
      if (d0 !== exp_d || idx0 !== 3'(i) || v0 !== 1'b1 || w0 !== 1'b0) begin
        n_bad++;
        $display("FAIL decode_%0d got d=%h idx=%0d v=%b w=%b want d=%h idx=%0d v=1 w=0",
                 i, d0, idx0, v0, w0, exp_d, i);
      end
    end
    ena = 1'b0;
    n3 = 3'd2;
    step();
    n_cmp++;
    if (d0 !== 8'h00 || v0 !== 1'b0 || idx0 !== 3'd7) begin
      n_bad++;
      $display("FAIL decode_disable got d=%h v=%b idx=%0d want d=00 v=0 idx=7", d0, v0, idx0);
    end
  endtask

  task automatic test_scan_up();
    logic [7:0] exp_d [4];
    logic       exp_w [4];
    exp_d = '{8'h40, 8'h80, 8'h01, 8'h02};
    exp_w = '{1'b0, 1'b0, 1'b1, 1'b0};
    ena = 1'b1; mode = 1'b0; n3 = 3'd6;
    step();
    mode = 1'b1; dir = 1'b0; n3 = 3'd0;
    for (int i = 0; i < 4; i++) begin
      step();
      n_cmp++;
      if (d0 !== exp_d[i] || w0 !== exp_w[i] || v0 !== 1'b1) begin
        n_bad++;
        $display("FAIL scan_up_%0d got d=%h w=%b v=%b want d=%h w=%b v=1",
                 i, d0, w0, v0, exp_d[i], exp_w[i]);
      end
    end
  endtask

  task automatic test_scan_down();
    // the 2-cycle ena gap sits after the second dwell cycle of idx 1
    logic [7:0] exp_d [11];
    logic       exp_w [11];
    logic       ena_v [11];
    logic [2:0] exp_i [11];
    exp_d = '{8'h02, 8'h02, 8'h00, 8'h00, 8'h02, 8'h01, 8'h01, 8'h01, 8'h80, 8'h80, 8'h80};
    exp_w = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    ena_v = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    exp_i = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd0, 3'd0, 3'd0, 3'd7, 3'd7, 3'd7};
    mode = 1'b1; dir = 1'b1; n3 = 3'd1;
    for (int i = 0; i < 11; i++) begin
      load = (i == 0);
      ena  = ena_v[i];
      step();
      n_cmp++;
      if (d3 !== exp_d[i] || w3 !== exp_w[i] || idx3 !== exp_i[i] || v3 !== ena_v[i]) begin
        n_bad++;
        $display("FAIL scan_down_%0d got d=%h w=%b idx=%0d v=%b want d=%h w=%b idx=%0d v=%b",
                 i, d3, w3, idx3, v3, exp_d[i], exp_w[i], exp_i[i], ena_v[i]);
      end
    end
    load = 1'b0;
  endtask

  task automatic test_load_reset();
    ena = 1'b1; mode = 1'b1; dir = 1'b0;
    load = 1'b1; n3 = 3'd3;
    step();
    n_cmp++;
    if (d0 !== 8'h08 || idx0 !== 3'd3) begin
      n_bad++; $display("FAIL load3 got d=%h idx=%0d want d=08 idx=3", d0, idx0);
    end
    n3 = 3'd0;
    step();
    n_cmp++;
    if (d0 !== 8'h01 || idx0 !== 3'd0 || w0 !== 1'b0) begin
      n_bad++; $display("FAIL load0 got d=%h idx=%0d w=%b want d=01 idx=0 w=0", d0, idx0, w0);
    end
    load = 1'b0;
    for (int i = 0; i < 5; i++) step();
    n_cmp++;
    if (d0 !== 8'h20 || idx0 !== 3'd5) begin
      n_bad++; $display("FAIL scan_to5 got d=%h idx=%0d want d=20 idx=5", d0, idx0);
    end
    rst = 1'b1;
    step();
    n_cmp++;
    if (d0 !== 8'h00 || idx0 !== 3'd0 || w0 !== 1'b0 || v0 !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_mid got d=%h idx=%0d w=%b v=%b want d=00 idx=0 w=0 v=0", d0, idx0, w0, v0);
    end
    // registered mode was cleared by reset, so this is a mode-change cycle
    rst = 1'b0;
    step();
    n_cmp++;
    if (d0 !== 8'h01 || idx0 !== 3'd0 || w0 !== 1'b0) begin
      n_bad++; $display("FAIL post_rst_hold got d=%h idx=%0d w=%b want d=01 idx=0 w=0", d0, idx0, w0);
    end
    load = 1'b1; n3 = 3'd7;
    step();
    load = 1'b0;
    rst = 1'b1;
    step();
    n_cmp++;
    if (w0 !== 1'b0 || idx0 !== 3'd0 || d0 !== 8'h00) begin
      n_bad++; $display("FAIL rst_at_max got d=%h idx=%0d w=%b want d=00 idx=0 w=0", d0, idx0, w0);
    end
    rst = 1'b0;
  endtask

  task automatic test_dir_change();
    ena = 1'b1; mode = 1'b1; dir = 1'b0;
    load = 1'b1; n3 = 3'd4;
    step();
    load = 1'b0;
    step();
    n_cmp++;
    if (idx0 !== 3'd5) begin n_bad++; $display("FAIL dir_up got idx=%0d want 5", idx0); end
    dir = 1'b1;
    step();
    step();
    n_cmp++;
    if (idx0 !== 3'd3 || d0 !== 8'h08) begin
      n_bad++; $display("FAIL dir_down got d=%h idx=%0d want d=08 idx=3", d0, idx0);
    end
  endtask

  task automatic test_polarity();
    ena = 1'b1; mode = 1'b0; n4 = 4'hA;
    step();
    n_cmp++;
    if (d4 !== 16'hFBFF || idx4 !== 4'hA || v4 !== 1'b1) begin
      n_bad++; $display("FAIL al_decode got d=%h idx=%h v=%b want d=FBFF idx=A v=1", d4, idx4, v4);
    end
    ena = 1'b0;
    step();
    n_cmp++;
    if (d4 !== 16'hFFFF || v4 !== 1'b0 || idx4 !== 4'hA) begin
      n_bad++; $display("FAIL al_disable got d=%h v=%b idx=%h want d=FFFF v=0 idx=A", d4, v4, idx4);
    end
    ena = 1'b1; n4 = 4'h0;
    step();
    n_cmp++;
    if (d4 !== 16'hFFFE) begin n_bad++; $display("FAIL al_decode0 got %h want FFFE", d4); end
    rst = 1'b1;
    step();
    n_cmp++;
    if (d4 !== 16'hFFFF || idx4 !== 4'h0 || v4 !== 1'b0) begin
      n_bad++; $display("FAIL al_reset got d=%h idx=%h v=%b want d=FFFF idx=0 v=0", d4, idx4, v4);
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_decode();
    test_scan_up();
    test_scan_down();
    test_load_reset();
    test_dir_change();
    test_polarity();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/decoder_scan_n.md
Name: decoder_scan_n

Overview:
- Parametrised, registered N-to-2^N one-hot decoder. Successor to the lab 3x8 decoder.
- Adds a scan mode: an internal index counter walks the one-hot output up or down at a programmable rate. Supports load, wrap flag and output polarity.
- Drives digit/row selects, e.g. 7-seg multiplexing and LED scanning, in later labs.

Parameters:
- N, 3, select width; output width is 2**N.
- DIV, 1, scan prescaler. Index steps once every DIV enabled cycles. Legal range 1..65535.
- ACTIVE_LOW, 0, 1 = output inverted (selected bit 0, others 1).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- ena  input  1  enable; 0 = outputs inactive, counters frozen
- mode  input  1  0 = decode n, 1 = scan
- dir  input  1  scan direction; 0 = up, 1 = down
- load  input  1  scan mode only: load n into index
- n  input  N  select value
- d  output  2**N  registered one-hot output, polarity per ACTIVE_LOW
- idx  output  N  registered current index
- valid  output  1  1 when d carries a selected line
- wrap  output  1  one-cycle pulse when scan index wraps

Behaviour:
- All outputs are registered and update only on the rising edge of clk. Priority order is rst > ena = 0 > load > step.
- Reset, applied when rst = 1 at an edge:
  - idx = 0, valid = 0, wrap = 0, prescaler = 0.
  - d = all-zero (ACTIVE_LOW = 0) or all-ones (ACTIVE_LOW = 1).
  - Reset mid-scan aborts the scan immediately; no wrap pulse.
- "Inactive" d means all-zero, or all-ones when ACTIVE_LOW = 1.
- ena = 0:
  - d goes inactive and valid = 0 at the next edge.
  - idx and prescaler hold; wrap = 0.
  - load is ignored.
- Decode mode (mode = 0, ena = 1):
  - idx <= n; d <= onehot(n); valid <= 1; wrap = 0.
  - Latency is 1 clock from n to d. The prescaler is held at 0.
- Scan mode (mode = 1, ena = 1):
  - d <= onehot(next idx); valid <= 1.
  - load = 1: idx <= n, prescaler <= 0, wrap <= 0. The output shows onehot(n) the next cycle.
  - Otherwise the prescaler counts 0..DIV-1. When prescaler == DIV-1, the prescaler clears and idx steps: +1 if dir = 0, -1 if dir = 1.
  - Otherwise idx holds and the prescaler increments.
  - DIV = 1 steps idx every enabled cycle.
- Wrap:
  - Up step from 2**N-1 to 0, or down step from 0 to 2**N-1, sets wrap = 1 for exactly one cycle.
  - The pulse is coincident with d showing the wrapped value. Otherwise wrap = 0.
- Mode change:
  - Any cycle where mode differs from its registered previous value clears the prescaler.
  - Scan continues from the current idx, i.e. the last decoded n. No step occurs in that cycle.
- A dir change takes effect at the next step; the prescaler is not cleared.
- Width rules:
  - idx arithmetic is modulo 2**N.
  - The prescaler is ceil(log2(DIV)) bits wide, minimum 1.
- Exactly one bit of d is active whenever valid = 1; none is active when valid = 0.

Test Plan:
- Reset: N=3, ACTIVE_LOW=0. Assert rst 2 cycles, then release with ena=0 -> d=8'h00, idx=0, valid=0, wrap=0.
- Decode sweep: mode=0, ena=1, n=0..7 one per cycle.
  - Each d appears 1 cycle after its n: n=5 -> d=8'h20, idx=5, valid=1.
  - Then ena=0 -> d=8'h00, valid=0, idx holds 7.
- Scan up with wrap: DIV=1, load n=6, then mode=1, dir=0.
  - d sequence 8'h40, 8'h80, 8'h01, 8'h02.
  - wrap=1 only in the cycle d=8'h01.
- Scan down with prescale: DIV=3, load n=1, dir=1.
  - d holds 8'h02 for 3 cycles, then 8'h01 for 3 cycles, then 8'h80 with wrap pulse.
  - ena=0 for 2 cycles mid-hold -> d=8'h00; dwell count resumes where frozen.
- Load/reset mid-scan: DIV=1, scanning up at idx=3.
  - load n=0 -> next d=8'h01, no wrap.
  - Then rst while idx=5 -> next cycle d=8'h00, idx=0, wrap=0.
- Polarity and width: ACTIVE_LOW=1, N=4, decode n=4'hA -> d=16'hFBFF. After reset, d=16'hFFFF.
